// File: rtl/fenwick_range_ctrl_pkg.sv
// Shared constants for the FENWICK range-XOR front-end: tree opcodes, request ops
// and the one-hot state encoding.
package fenwick_range_ctrl_pkg;

  localparam logic [1:0] FW_UPD = 2'b00;
  localparam logic [1:0] FW_QLD = 2'b11;
  localparam logic [1:0] FW_QRD = 2'b01;

  localparam logic OP_UPD = 1'b0;
  localparam logic OP_RNG = 1'b1;

  localparam int NUM_ST = 7;
  typedef logic [NUM_ST-1:0] state_t;

  localparam state_t ST_IDLE  = 7'b0000001;
  localparam state_t ST_UPD   = 7'b0000010;
  localparam state_t ST_Q1_LD = 7'b0000100;
  localparam state_t ST_Q1_RD = 7'b0001000;
  localparam state_t ST_Q2_LD = 7'b0010000;
  localparam state_t ST_Q2_RD = 7'b0100000;
  localparam state_t ST_RESP  = 7'b1000000;

endpackage

// File: rtl/fenwick_range_ctrl.sv
// Command front-end for the FENWICK 1-bit XOR tree: point updates and range-XOR
// queries computed as prefix(r) ^ prefix(l-1), all outputs registered.
module fenwick_range_ctrl
  import fenwick_range_ctrl_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [IDX_W-1:0] req_l,
  input  logic [IDX_W-1:0] req_r,
  input  logic             req_val,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_data,
  output logic             resp_err,
  output logic [1:0]       fw_inst,
  output logic [IDX_W-1:0] fw_idx,
  output logic             fw_val,
  input  logic             fw_rangexor
);

  state_t           state, nxt;
  logic [IDX_W-1:0] l_q, r_q, l_dec;
  logic             acc, acc_d;
  logic             accept;

  logic [1:0]       inst_d;
  logic [IDX_W-1:0] idx_d;
  logic             val_d, rv_d, rd_d, re_d, rr_d;

  // req_ready is registered high exactly while in IDLE
  assign accept = req_valid & req_ready;
  // only consumed in Q2 states, which are reached solely when l > 0
  assign l_dec  = l_q - IDX_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = ST_IDLE;
    case (state)
      ST_IDLE: begin
        nxt = ST_IDLE;
        if (req_valid) begin
          if (req_op == OP_UPD)   nxt = ST_UPD;
          else if (req_l <= req_r) nxt = ST_Q1_LD;
          else                    nxt = ST_RESP;
        end
      end
      ST_UPD:   nxt = ST_IDLE;
      ST_Q1_LD: nxt = ST_Q1_RD;
      ST_Q1_RD: nxt = (l_q == '0) ? ST_RESP : ST_Q2_LD;
      ST_Q2_LD: nxt = ST_Q2_RD;
      ST_Q2_RD: nxt = ST_RESP;
      ST_RESP:  nxt = resp_ready ? ST_IDLE : ST_RESP;
      default:  nxt = ST_IDLE;
    endcase
  end

  // Output D-values are derived from the next state so every pin is a flop.
  always_comb begin
    acc_d  = acc;
    inst_d = FW_UPD;
    idx_d  = '0;
    val_d  = 1'b0;
    rv_d   = 1'b0;
    rd_d   = 1'b0;
    re_d   = 1'b0;
    rr_d   = 1'b0;
    case (state)
      ST_IDLE:  if (accept) acc_d = 1'b0;
      ST_Q1_RD: acc_d = fw_rangexor;
      ST_Q2_RD: acc_d = acc ^ fw_rangexor;
      default:  acc_d = acc;
    endcase
    case (nxt)
      ST_IDLE:  rr_d = 1'b1;
      ST_UPD: begin
        idx_d = req_l;
        val_d = req_val;
      end
      ST_Q1_LD: begin
        inst_d = FW_QLD;
        idx_d  = req_r;
      end
      ST_Q1_RD: begin
        inst_d = FW_QRD;
        idx_d  = r_q;
      end
      ST_Q2_LD: begin
        inst_d = FW_QLD;
        idx_d  = l_dec;
      end
      ST_Q2_RD: begin
        inst_d = FW_QRD;
        idx_d  = l_dec;
      end
      ST_RESP: begin
        rv_d = 1'b1;
        rd_d = acc_d;
        re_d = (state == ST_IDLE) | ((state == ST_RESP) & resp_err);
      end
      default: rr_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      l_q        <= '0;
      r_q        <= '0;
      acc        <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= 1'b0;
      resp_err   <= 1'b0;
      fw_inst    <= FW_UPD;
      fw_idx     <= '0;
      fw_val     <= 1'b0;
    end else begin
      if (accept) begin
        l_q <= req_l;
        r_q <= req_r;
      end
      acc        <= acc_d;
      req_ready  <= rr_d;
      resp_valid <= rv_d;
      resp_data  <= rd_d;
      resp_err   <= re_d;
      fw_inst    <= inst_d;
      fw_idx     <= idx_d;
      fw_val     <= val_d;
    end
  end

endmodule

// File: tb/tb_fenwick_range_ctrl.sv
// Directed bench: controller driving a behavioural FENWICK tree, with a response
// scoreboard popped by a free-running monitor.
module tb_fenwick_range_ctrl;
  import fenwick_range_ctrl_pkg::*;

  localparam int IDX_W = 3;
  localparam int N     = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid, req_ready, req_op, req_val;
  logic [IDX_W-1:0] req_l, req_r;
  logic             resp_valid, resp_ready, resp_data, resp_err;
  logic [1:0]       fw_inst;
  logic [IDX_W-1:0] fw_idx;
  logic             fw_val, fw_rangexor;

  fenwick_range_ctrl #(.IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_l(req_l), .req_r(req_r), .req_val(req_val),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .fw_inst(fw_inst), .fw_idx(fw_idx), .fw_val(fw_val),
    .fw_rangexor(fw_rangexor)
  );

  always #5 clk = ~clk;

  // Behavioural FENWICK: elements accumulate by XOR; reset is ~reset (active high)
  logic             fw_rst;
  logic [N-1:0]     mem;
  logic [IDX_W-1:0] ld_idx;
  assign fw_rst = ~reset;
  always @(posedge clk or posedge fw_rst) begin
    if (fw_rst) begin
      mem    <= '0;
      ld_idx <= '0;
    end else begin
      if (fw_inst == FW_UPD) mem[fw_idx] <= mem[fw_idx] ^ fw_val;
      if (fw_inst == FW_QLD) ld_idx <= fw_idx;
    end
  end
  always_comb begin
    fw_rangexor = 1'b0;
    for (int i = 0; i < N; i++)
      if (i <= int'(ld_idx)) fw_rangexor = fw_rangexor ^ mem[i];
  end

  typedef struct { logic data; logic err; int lat; } exp_t;
  exp_t exp_q[$];
  logic [IDX_W+1:0] trace[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Monitor: latency counted in cycles from the accept edge
  int   since  = 0;
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    since++;
    if (reset) begin
      if (resp_valid && req_ready) chk("ready_while_valid", 1, 0);
      if (resp_valid && !prev_v) begin
        if (exp_q.size() == 0) chk("unexpected_resp", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("resp_data", int'(resp_data), int'(e.data));
          chk("resp_err", int'(resp_err), int'(e.err));
          chk("resp_lat", since, e.lat);
        end
      end
      if (fw_inst != FW_UPD) trace.push_back({fw_inst, fw_idx});
      if (req_valid && req_ready) since = 0;
    end
    prev_v = resp_valid;
  end

  // Drives one request; returns #1 after the accept edge
  task automatic issue(input logic op, input int l, input int r, input logic v);
    int n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_val = v;
    req_l = IDX_W'(l); req_r = IDX_W'(r);
    while (!req_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic upd(input int l, input logic v);
    issue(OP_UPD, l, 0, v);
    chk("upd_inst", int'(fw_inst), int'(FW_UPD));
    chk("upd_idx", int'(fw_idx), l);
    chk("upd_val", int'(fw_val), int'(v));
    @(posedge clk); #1;
    chk("upd_val_after", int'(fw_val), 0);
    chk("upd_ready_after", int'(req_ready), 1);
  endtask

  task automatic query(input int l, input int r, input logic d, input logic err, input int lat);
    exp_t e;
    e.data = d; e.err = err; e.lat = lat;
    exp_q.push_back(e);
    issue(OP_RNG, l, r, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    reset = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_val = 1'b0;
    req_l = '0; req_r = '0; resp_ready = 1'b1;

    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_ready", int'(req_ready), 1);
      chk("rst_valid", int'(resp_valid), 0);
      chk("rst_inst", int'(fw_inst), 0);
      chk("rst_val", int'(fw_val), 0);
    end
    @(posedge clk); #1 reset = 1'b1;

    // element 0 toggles on then the val=0 update leaves it; element 4 set
    upd(0, 1'b1);
    upd(0, 1'b0);
    upd(4, 1'b1);
    query(0, 7, 1'b0, 1'b0, 3);
    drain();

    query(0, 3, 1'b1, 1'b0, 3);
    drain();
    trace.delete();
    query(4, 4, 1'b1, 1'b0, 5);
    drain();
    chk("trace_len", trace.size(), 4);
    if (trace.size() == 4) begin
      chk("trace0", int'(trace[0]), int'({FW_QLD, 3'd4}));
      chk("trace1", int'(trace[1]), int'({FW_QRD, 3'd4}));
      chk("trace2", int'(trace[2]), int'({FW_QLD, 3'd3}));
      chk("trace3", int'(trace[3]), int'({FW_QRD, 3'd3}));
    end

    // tree now: e0=1^1=0, e4=1, e5=1, e6=1
    upd(5, 1'b1);
    upd(6, 1'b1);
    upd(0, 1'b1);
    query(1, 3, 1'b0, 1'b0, 5);
    query(4, 7, 1'b1, 1'b0, 5);
    query(5, 6, 1'b0, 1'b0, 5);
    query(7, 7, 1'b0, 1'b0, 5);
    query(0, 0, 1'b0, 1'b0, 3);
    drain();

    trace.delete();
    resp_ready = 1'b0;
    query(6, 2, 1'b0, 1'b1, 1);
    for (int c = 0; c < 4; c++) begin
      chk("bp_valid", int'(resp_valid), 1);
      chk("bp_data", int'(resp_data), 0);
      chk("bp_err", int'(resp_err), 1);
      chk("bp_ready", int'(req_ready), 0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", int'(resp_valid), 0);
    chk("bp_ready_back", int'(req_ready), 1);
    chk("err_no_query", trace.size(), 0);
    chk("err_popped", exp_q.size(), 0);

    issue(OP_RNG, 5, 6, 1'b0);
    n = 0;
    while (!(fw_inst == FW_QLD && fw_idx == 3'd4) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("reached_q2_ld", n < 20 ? 1 : 0, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", int'(req_ready), 1);
    chk("mid_rst_valid", int'(resp_valid), 0);
    chk("mid_rst_data", int'(resp_data), 0);
    chk("mid_rst_err", int'(resp_err), 0);
    chk("mid_rst_inst", int'(fw_inst), 0);
    chk("mid_rst_idx", int'(fw_idx), 0);
    chk("mid_rst_val", int'(fw_val), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    // FENWICK was cleared by the same reset, so [4,4] reads 0 until rewritten
    query(4, 4, 1'b0, 1'b0, 5);
    drain();
    upd(4, 1'b1);
    query(4, 4, 1'b1, 1'b0, 5);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
